// File: rtl/eeprom_page_ctrl.sv
// EEPROM word-address pointer, one-page write buffer and page committer; ack/nack one cycle after strobe, strobes nacked while busy.
// Optional EEPROM_WP_EN adds a wp input that suppresses array writes for a commit accepted while wp=1.
module eeprom_page_ctrl #(
  parameter int ADDR_W = 8,
  parameter int PAGE_W = 3,
  parameter int DATA_W = 8,
  parameter int WR_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_byte,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_byte,
  input  logic              commit,
`ifdef EEPROM_WP_EN
  input  logic              wp,
`endif
  output logic              ack,
  output logic              nack,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PAGE_N = 1 << PAGE_W;
  localparam int CNT_W  = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_CYC - 1);

  typedef enum logic [1:0] {IDLE, COMMIT, WAIT} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic [PAGE_W-1:0]   off;
  logic [PAGE_N-1:0]   valid;
  logic [DATA_W-1:0]   pbuf [PAGE_N];
  logic [PAGE_W-1:0]   idx;
  logic [CNT_W-1:0]    wcnt;
  logic                idle, any_strobe, multi_strobe;
  logic                take_commit, take_load, take_wr, take_rd;
  logic                ack_nxt, nack_nxt, wp_hold;

  assign off = ptr[PAGE_W-1:0];

  // Fixed priority commit > load_addr > wr_byte > rd_byte; losers are nacked alongside the winner's ack.
  always_comb begin
    idle         = (state == IDLE);
    any_strobe   = commit | load_addr | wr_byte | rd_byte;
    multi_strobe = (commit & (load_addr | wr_byte | rd_byte)) |
                   (load_addr & (wr_byte | rd_byte)) |
                   (wr_byte & rd_byte);
    take_commit  = idle & commit;
    take_load    = idle & ~commit & load_addr;
    take_wr      = idle & ~commit & ~load_addr & wr_byte;
    take_rd      = idle & ~commit & ~load_addr & ~wr_byte & rd_byte;
    ack_nxt      = idle & any_strobe;
    nack_nxt     = idle ? multi_strobe : any_strobe;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take_commit && (|valid)) state_nxt = COMMIT;
      COMMIT:  if (&idx) state_nxt = WAIT;
      WAIT:    if (wcnt == CNT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = ~idle;
    mem_addr  = ptr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state == COMMIT) begin
      mem_addr  = {ptr[ADDR_W-1:PAGE_W], idx};
      mem_we    = valid[idx] & ~wp_hold;
      mem_wdata = pbuf[idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      valid   <= '0;
      idx     <= '0;
      wcnt    <= '0;
      ack     <= 1'b0;
      nack    <= 1'b0;
      rdata_o <= '0;
    end else begin
      state <= state_nxt;
      ack   <= ack_nxt;
      nack  <= nack_nxt;
      if (take_load) ptr <= addr_i;
      if (take_wr) begin
        valid[off]         <= 1'b1;
        ptr[PAGE_W-1:0]    <= off + PAGE_W'(1);
      end
      if (take_rd) begin
        rdata_o <= mem_rdata;
        ptr     <= ptr + ADDR_W'(1);
      end
      if (state == COMMIT) idx <= idx + PAGE_W'(1);
      else                 idx <= '0;
      if (state == COMMIT && (&idx)) valid <= '0;
      if (state == WAIT) wcnt <= wcnt + CNT_W'(1);
      else               wcnt <= '0;
    end
  end

  // Buffer data needs no reset: the valid bits alone decide what is committed.
  always_ff @(posedge clk) begin
    if (take_wr) pbuf[off] <= wdata_i;
  end

`ifdef EEPROM_WP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            wp_hold <= 1'b0;
    else if (take_commit) wp_hold <= wp;
  end
`else
  assign wp_hold = 1'b0;
`endif

endmodule

// File: tb/tb_eeprom_page_ctrl.sv
// Scoreboard bench for eeprom_page_ctrl: a reference model predicts ack/nack/rdata per strobe, a monitor checks them.
module tb_eeprom_page_ctrl;

  localparam int AW = 8, PW = 3, DW = 8, WC = 4;
  localparam int PN = 1 << PW;
  localparam int DEPTH = 1 << AW;
  localparam int BUSY_LEN = PN + WC;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_addr, wr_byte, rd_byte, commit;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic          ack, nack, busy, mem_we;
  logic [DW-1:0] rdata_o, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem [DEPTH];
  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  eeprom_page_ctrl #(.ADDR_W(AW), .PAGE_W(PW), .DATA_W(DW), .WR_CYC(WC)) dut (
    .clk(clk), .reset(reset),
    .load_addr(load_addr), .addr_i(addr_i),
    .wr_byte(wr_byte), .wdata_i(wdata_i),
    .rd_byte(rd_byte), .commit(commit),
`ifdef EEPROM_WP_EN
    .wp(1'b0),
`endif
    .ack(ack), .nack(nack), .rdata_o(rdata_o), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          ack;
    logic          nack;
    logic          rd;
    logic [DW-1:0] rdata;
  } resp_t;

  resp_t         exp_q[$];
  int            n_cmp = 0, n_err = 0;
  int            busy_total = 0, we_total = 0;

  // Reference model: pointer, page buffer and array image, plus the cycle at which strobes are accepted again.
  int unsigned   m_ptr;
  logic [DW-1:0] m_buf [PN];
  bit            m_val [PN];
  logic [DW-1:0] ref_mem [DEPTH];
  int            tcur = 0, free_at = 0, abort_lim = -1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    free_at = 0;
    for (int i = 0; i < PN; i++) m_val[i] = 1'b0;
    exp_q.delete();
  endtask

  task automatic strobe(input bit c, input bit l, input bit w, input bit r,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    resp_t e;
    int n;
    int unsigned base;
    bit any;
    n = int'(c) + int'(l) + int'(w) + int'(r);
    e = '{ack: 1'b0, nack: 1'b0, rd: 1'b0, rdata: '0};
    if (n > 0) begin
      if (tcur < free_at) begin
        e.nack = 1'b1;
      end else begin
        e.ack  = 1'b1;
        e.nack = (n > 1);
        base   = m_ptr - (m_ptr % PN);
        if (c) begin
          any = 1'b0;
          for (int i = 0; i < PN; i++) any |= m_val[i];
          if (any) begin
            for (int i = 0; i < PN; i++) begin
              if (m_val[i] && (abort_lim < 0 || i < abort_lim)) ref_mem[base + i] = m_buf[i];
              m_val[i] = 1'b0;
            end
            free_at = tcur + BUSY_LEN + 1;
          end
        end else if (l) begin
          m_ptr = a;
        end else if (w) begin
          m_buf[m_ptr % PN] = d;
          m_val[m_ptr % PN] = 1'b1;
          m_ptr = base + ((m_ptr + 1) % PN);
        end else begin
          e.rd    = 1'b1;
          e.rdata = ref_mem[m_ptr];
          m_ptr   = (m_ptr + 1) % DEPTH;
        end
      end
      exp_q.push_back(e);
    end
    commit = c; load_addr = l; wr_byte = w; rd_byte = r; addr_i = a; wdata_i = d;
    @(posedge clk);
    #1;
    commit = 1'b0; load_addr = 1'b0; wr_byte = 1'b0; rd_byte = 1'b0;
    tcur++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) strobe(0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    int b0, w0;
    logic [DW-1:0] old63;
    reset = 1'b1;
    load_addr = 1'b0; wr_byte = 1'b0; rd_byte = 1'b0; commit = 1'b0;
    addr_i = '0; wdata_i = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    model_reset();

    fork
      forever begin
        @(posedge clk);
        if (mem_we) mem[mem_addr] <= mem_wdata;
      end
      forever begin
        resp_t e;
        @(negedge clk);
        if (busy) busy_total++;
        if (mem_we) we_total++;
        if (!reset && (ack || nack)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", {30'd0, ack, nack}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ack", 32'(ack), 32'(e.ack));
            check("nack", 32'(nack), 32'(e.nack));
            if (e.rd) check("rdata", 32'(rdata_o), 32'(e.rdata));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_nack", 32'(nack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rdata", 32'(rdata_o), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    reset = 1'b0;
    idle(2);

    // In-page wrap: three bytes from 0x1E land at 0x1E, 0x1F, 0x18.
    b0 = busy_total;
    strobe(0, 1, 0, 0, 8'h1E, '0);
    strobe(0, 0, 1, 0, '0, 8'hA1);
    strobe(0, 0, 1, 0, '0, 8'hB2);
    strobe(0, 0, 1, 0, '0, 8'hC3);
    strobe(1, 0, 0, 0, '0, '0);
    idle(14);
    check("wrap_busy_len", 32'(busy_total - b0), 32'(BUSY_LEN));
    check("wrap_1E", 32'(mem[8'h1E]), 32'h A1);
    check("wrap_1F", 32'(mem[8'h1F]), 32'h B2);
    check("wrap_18", 32'(mem[8'h18]), 32'h C3);

    // Sequential read across the top of the array.
    strobe(0, 1, 0, 0, 8'hFF, '0);
    strobe(0, 0, 0, 1, '0, '0);
    strobe(0, 0, 0, 1, '0, '0);

    // Busy rejection, including the last busy cycle and the first free one.
    strobe(0, 1, 0, 0, 8'h30, '0);
    strobe(0, 0, 1, 0, '0, 8'h11);
    strobe(1, 0, 0, 0, '0, '0);
    strobe(0, 0, 0, 1, '0, '0);
    strobe(0, 0, 1, 0, '0, 8'h99);
    strobe(0, 1, 0, 0, 8'h77, '0);
    idle(8);
    strobe(0, 0, 0, 1, '0, '0);
    strobe(0, 0, 0, 1, '0, '0);
    idle(2);

    // Empty commit.
    strobe(0, 1, 0, 0, 8'h40, '0);
    b0 = busy_total; w0 = we_total;
    strobe(1, 0, 0, 0, '0, '0);
    idle(3);
    check("empty_busy", 32'(busy_total - b0), 0);
    check("empty_we", 32'(we_total - w0), 0);

    // Priority: load wins over write and read; then commit wins over everything.
    strobe(0, 1, 1, 1, 8'h5A, 8'hEE);
    strobe(0, 0, 0, 1, '0, '0);
    b0 = busy_total;
    strobe(1, 1, 0, 1, 8'h10, '0);
    idle(2);
    check("prio_no_buf_write", 32'(busy_total - b0), 0);
    strobe(0, 0, 0, 1, '0, '0);

    // Reset while the commit scan is at index 3.
    old63 = mem[8'h63];
    strobe(0, 1, 0, 0, 8'h60, '0);
    for (int k = 0; k < 4; k++) strobe(0, 0, 1, 0, '0, DW'(8'hD0 + k));
    strobe(0, 1, 0, 0, 8'h65, '0);
    strobe(0, 0, 1, 0, '0, 8'hD5);
    abort_lim = 3;
    strobe(1, 0, 0, 0, '0, '0);
    abort_lim = -1;
    idle(3);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_we", 32'(mem_we), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("abort_62", 32'(mem[8'h62]), 32'h D2);
    check("abort_63", 32'(mem[8'h63]), 32'(old63));
    b0 = busy_total;
    strobe(1, 0, 0, 0, '0, '0);
    idle(2);
    check("abort_valid_clear", 32'(busy_total - b0), 0);

    // Randomised traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      strobe($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             AW'($urandom), DW'($urandom));
    end
    idle(BUSY_LEN + 4);

    for (int i = 0; i < DEPTH; i++) check($sformatf("array_%0h", i), 32'(mem[i]), 32'(ref_mem[i]));
    check("pending_resp", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eeprom_page_ctrl.md
# eeprom_page_ctrl

Parametrised address-pointer and page-write controller for the I2C EEPROM slave model. It sits between the I2C byte-level slave front end and the EEPROM storage array. It does three things:
- Holds the current word address.
- Buffers up to one page of write data with in-page wrap-around.
- Commits that page to the array after the stop condition, emulating the internal write cycle as a busy period.

Sequential reads walk the full array with wrap-around.

## Interface
- `ADDR_W`, 8: word address width; array depth is 2^ADDR_W.
- `PAGE_W`, 3: in-page offset width; page size is 2^PAGE_W bytes. Must be less than `ADDR_W`.
- `DATA_W`, 8: data word width.
- `WR_CYC`, 4: emulated write-cycle length in clocks, ≥1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `load_addr`  in  1  strobe: load pointer from `addr_i`.
- `addr_i`  in  `ADDR_W`  word address.
- `wr_byte`  in  1  strobe: buffer `wdata_i` at the pointer's page offset.
- `wdata_i`  in  `DATA_W`  write byte.
- `rd_byte`  in  1  strobe: read the array at the pointer.
- `commit`  in  1  strobe (stop condition): start the page write.
- `ack`  out  1  registered one-cycle pulse: strobe accepted.
- `nack`  out  1  registered one-cycle pulse: strobe rejected.
- `rdata_o`  out  `DATA_W`  registered read data.
- `busy`  out  1  commit or write cycle in progress.
- `mem_addr`  out  `ADDR_W`  array address.
- `mem_we`  out  1  array write enable.
- `mem_wdata`  out  `DATA_W`  array write data.
- `mem_rdata`  in  `DATA_W`  array read data, combinational from `mem_addr`.

## Operation
- **Pointer** = {page[`ADDR_W-1`:`PAGE_W`], off[`PAGE_W-1`:0]}.
- **Page buffer**: 2^`PAGE_W` × `DATA_W` entries, each with a valid bit.
- **FSM states**: IDLE, COMMIT, WAIT.
- **IDLE**
  - `load_addr`: pointer ← `addr_i`.
  - `wr_byte`: buf[off] ← `wdata_i`; valid[off] ← 1; off ← off+1, wrapping inside the page (page bits unchanged). A 9th byte into an 8-byte page overwrites entry 0.
  - `rd_byte`: `mem_addr` = pointer; `rdata_o` ← `mem_rdata`; pointer ← pointer+1, wrapping at 2^`ADDR_W` to 0.
  - `commit` with any valid bit set: go to COMMIT with scan index 0.
  - `commit` with no valid bits set: ack only, stay in IDLE, no array write.
- **COMMIT** takes 2^`PAGE_W` cycles, scanning index i = 0..2^`PAGE_W`-1.
  - `mem_addr` = {page, i}; `mem_wdata` = buf[i]; `mem_we` = valid[i].
  - After the last index: clear all valid bits and go to WAIT.
- **WAIT**: count `WR_CYC` cycles, then go to IDLE.
- **Busy rejection**: `busy` = 1 in COMMIT and WAIT. Every strobe during busy gets `nack` and has no effect.
- **Pointer after commit**: unchanged from its last `wr_byte`-incremented value.
- **Simultaneous strobes**: priority `commit` > `load_addr` > `wr_byte` > `rd_byte`. The winner is acked; every other asserted strobe gets `nack` in the same cycle.
- **Reset**
  - Pointer 0, valid bits 0, FSM IDLE.
  - Outputs: `ack` 0, `nack` 0, `rdata_o` 0, `busy` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0.
  - Reset during COMMIT aborts the commit. Array writes already made remain.

## Timing
- `ack`/`nack` assert one cycle after the strobe cycle.
- `rdata_o` is valid one cycle after `rd_byte`.
- `commit` accepted at cycle T:
  - `busy` is high from T+1 through T+2^`PAGE_W`+`WR_CYC`.
  - Strobes are accepted again at T+2^`PAGE_W`+`WR_CYC`+1.
- `mem_we` is asserted only during COMMIT, for at most one address per cycle, in ascending offset order.
- Buffer contents are visible to `rd_byte` only after commit; there is no read-through of the buffer.

## Configuration
- **`EEPROM_WP_EN` defined**
  - Adds input `wp` (1 bit).
  - A commit accepted while `wp`=1 still runs the full busy sequence, but `mem_we` is held 0 and the buffer is discarded.
  - `ack` is unchanged.
- **`EEPROM_WP_EN` undefined**: no `wp` port; all commits write the array.

## Test plan
Defaults throughout: `ADDR_W`=8, `PAGE_W`=3, `WR_CYC`=4.
- **In-page wrap**: load 0x1E, write A,B,C, commit → array[0x1E]=A, [0x1F]=B, [0x18]=C; `busy` high exactly 12 cycles.
- **Sequential read wrap**: load 0xFF, two `rd_byte` → `rdata_o` = array[0xFF], then array[0x00].
- **Busy rejection**: a strobe during `busy` → `nack` pulse; pointer and array unchanged; after `busy` falls, `rd_byte` is acked.
- **Empty commit**: load 0x40, commit with no writes → `ack`, `busy` stays 0, `mem_we` never asserts.
- **Priority**: `load_addr`, `wr_byte` and `rd_byte` in the same cycle → `ack`, pointer = `addr_i`, `nack` for the others, no buffer write.
- **Reset mid-commit**: reset during COMMIT index 3 → `busy` 0, valid bits cleared, entries 0–2 already written.
